ans_checker: RTL and testbench

ANS_CHECKER -- requirements
Module: ans_checker

---
 rtl/ans_checker_if.sv | 31 +++
 rtl/ans_checker.sv | 108 ++++++++++
 tb/tb_ans_checker.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ans_checker_if.sv
// Bundles the ans_checker run control, result and shared memory read port signals.
// The slave modport is the checker side; the master modport is the controller/memory side.
interface ans_checker_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  start;
    logic [31:0]           base_addr;
    logic [10:0]           num_words;
    logic [31:0]           mem_addr;
    logic [WORD_WIDTH-1:0] ans_data;
    logic [WORD_WIDTH-1:0] dut_data;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [10:0]           err_count;
    logic [31:0]           first_err_addr;
    logic [WORD_WIDTH-1:0] first_err_exp;
    logic [WORD_WIDTH-1:0] first_err_got;

    modport slave (
        input  start, base_addr, num_words, ans_data, dut_data,
        output mem_addr, busy, done, pass, err_count,
               first_err_addr, first_err_exp, first_err_got
    );

    modport master (
        output start, base_addr, num_words, ans_data, dut_data,
        input  mem_addr, busy, done, pass, err_count,
               first_err_addr, first_err_exp, first_err_got
    );
endinterface

// File: rtl/ans_checker.sv
// ans_checker: compares answer memory against DUT memory one word per cycle.
// Latency num_words+1 cycles from start to done; no backpressure, start is ignored outside IDLE.
module ans_checker #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_STEP  = 4
) (
    input  logic          clk,
    input  logic          nrst,
    ans_checker_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [10:0] ERR_MAX = 11'h7FF;

    state_t                state;
    logic [10:0]           remaining;
    logic [31:0]           mem_addr_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  pass_q;
    logic [10:0]           err_count_q;
    logic [31:0]           first_addr_q;
    logic [WORD_WIDTH-1:0] first_exp_q;
    logic [WORD_WIDTH-1:0] first_got_q;
    logic                  mismatch;

    assign mismatch = (bus.ans_data != bus.dut_data);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= IDLE;
            remaining    <= '0;
            mem_addr_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_count_q  <= '0;
            first_addr_q <= '0;
            first_exp_q  <= '0;
            first_got_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        err_count_q  <= '0;
                        pass_q       <= 1'b0;
                        first_addr_q <= '0;
                        first_exp_q  <= '0;
                        first_got_q  <= '0;
                        if (bus.num_words != 11'd0) begin
                            state      <= CHECK;
                            busy_q     <= 1'b1;
                            mem_addr_q <= bus.base_addr;
                            remaining  <= bus.num_words;
                        end else begin
                            // Empty run: skip straight to DONE, address untouched.
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        if (err_count_q == 11'd0) begin
                            first_addr_q <= mem_addr_q;
                            first_exp_q  <= bus.ans_data;
                            first_got_q  <= bus.dut_data;
                        end
                        if (err_count_q != ERR_MAX) begin
                            err_count_q <= err_count_q + 11'd1;
                        end
                    end
                    mem_addr_q <= mem_addr_q + 32'(ADDR_STEP);
                    remaining  <= remaining - 11'd1;
                    if (remaining == 11'd1) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    pass_q <= (err_count_q == 11'd0);
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_addr       = mem_addr_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;
    assign bus.err_count      = err_count_q;
    assign bus.first_err_addr = first_addr_q;
    assign bus.first_err_exp  = first_exp_q;
    assign bus.first_err_got  = first_got_q;
endmodule

// File: tb/tb_ans_checker.sv
// Directed table-driven bench for ans_checker with a 16-word memory model.
module tb_ans_checker;
    logic clk;
    logic nrst;

    ans_checker_if #(.WORD_WIDTH(32)) bus ();

    ans_checker #(.WORD_WIDTH(32), .ADDR_STEP(4)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ans_mem [0:15];
    logic [31:0] dut_mem [0:15];
    logic        all_bad;

    assign bus.ans_data = ans_mem[bus.mem_addr[5:2]];
    assign bus.dut_data = all_bad ? ~ans_mem[bus.mem_addr[5:2]] : dut_mem[bus.mem_addr[5:2]];

    typedef struct {
        logic [31:0] base;
        logic [10:0] num;
        int          kind;
        logic [10:0] exp_err;
        logic        exp_pass;
        logic [31:0] exp_faddr;
        logic [31:0] exp_fexp;
        logic [31:0] exp_fgot;
    } vec_t;

    vec_t vt [6];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic setup_mem(input int kind);
        for (int i = 0; i < 16; i++) begin
            ans_mem[i] = 32'h1000_0000 + i * 32'h0101_0101;
            dut_mem[i] = 32'h1000_0000 + i * 32'h0101_0101;
        end
        all_bad = 1'b0;
        case (kind)
            1: begin
                ans_mem[2] = 32'h1234_5678;
                dut_mem[2] = 32'hDEAD_BEEF;
            end
            2: begin
                dut_mem[1] = ans_mem[1] ^ 32'h0000_0001;
                dut_mem[3] = ans_mem[3] ^ 32'h0000_00FF;
            end
            3: all_bad = 1'b1;
            default: ;
        endcase
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  cyc;
        int  k;
        logic saw_busy;
        logic got_done;
        logic [31:0] exp_addr;
        setup_mem(v.kind);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = v.base;
        bus.num_words = v.num;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        cyc      = 1;
        k        = 0;
        saw_busy = 1'b0;
        got_done = 1'b0;
        while (!got_done && cyc < int'(v.num) + 20) begin
            if (bus.done) begin
                got_done = 1'b1;
            end else begin
                if (bus.busy) begin
                    saw_busy = 1'b1;
                    if (v.num <= 11'd16) begin
                        exp_addr = v.base + 32'(k * 4);
                        chk($sformatf("v%0d_addr%0d", idx, k), bus.mem_addr, exp_addr);
                    end
                    k++;
                end
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        chk($sformatf("v%0d_done_seen", idx), 32'(got_done), 32'd1);
        chk($sformatf("v%0d_latency", idx), 32'(cyc), 32'(int'(v.num) + 1));
        chk($sformatf("v%0d_busy_seen", idx), 32'(saw_busy), 32'(v.num != 11'd0));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_done_pulse", idx), 32'(bus.done), 32'd0);
        chk($sformatf("v%0d_busy_after", idx), 32'(bus.busy), 32'd0);
        chk($sformatf("v%0d_pass", idx), 32'(bus.pass), 32'(v.exp_pass));
        chk($sformatf("v%0d_err_count", idx), 32'(bus.err_count), 32'(v.exp_err));
        chk($sformatf("v%0d_first_addr", idx), bus.first_err_addr, v.exp_faddr);
        chk($sformatf("v%0d_first_exp", idx), bus.first_err_exp, v.exp_fexp);
        chk($sformatf("v%0d_first_got", idx), bus.first_err_got, v.exp_fgot);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  32'(bus.busy), 32'd0);
        chk({tag, "_done"},  32'(bus.done), 32'd0);
        chk({tag, "_pass"},  32'(bus.pass), 32'd0);
        chk({tag, "_err"},   32'(bus.err_count), 32'd0);
        chk({tag, "_addr"},  bus.mem_addr, 32'd0);
        chk({tag, "_faddr"}, bus.first_err_addr, 32'd0);
        chk({tag, "_fexp"},  bus.first_err_exp, 32'd0);
        chk({tag, "_fgot"},  bus.first_err_got, 32'd0);
    endtask

    initial begin
        logic bad_after;
        vt[0] = '{32'h0000_0000, 11'd4,    0, 11'd0,    1'b1, 32'h0, 32'h0,         32'h0};
        vt[1] = '{32'h0000_0000, 11'd4,    1, 11'd1,    1'b0, 32'h8, 32'h1234_5678, 32'hDEAD_BEEF};
        vt[2] = '{32'h0000_0000, 11'd4,    2, 11'd2,    1'b0, 32'h4, 32'h1101_0101, 32'h1101_0100};
        vt[3] = '{32'h0000_0000, 11'd0,    0, 11'd0,    1'b1, 32'h0, 32'h0,         32'h0};
        vt[4] = '{32'hFFFF_FFFC, 11'd2,    0, 11'd0,    1'b1, 32'h0, 32'h0,         32'h0};
        vt[5] = '{32'h0000_0000, 11'd2047, 3, 11'd2047, 1'b0, 32'h0, 32'h1000_0000, 32'hEFFF_FFFF};

        setup_mem(0);
        nrst          = 1'b0;
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.num_words = '0;
        #1;
        chk_all_zero("reset");
        repeat (3) @(negedge clk);
        nrst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_vec(i, vt[i]);
        end

        // Abort mid-run: second start while busy must not disturb the scan.
        setup_mem(0);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = 32'h0;
        bus.num_words = 11'd8;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("abort_word2_addr", bus.mem_addr, 32'h8);
        bus.start     = 1'b1;
        bus.base_addr = 32'h40;
        bus.num_words = 11'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("abort_ignore_start_addr", bus.mem_addr, 32'hC);
        chk("abort_still_busy", 32'(bus.busy), 32'd1);
        #2;
        nrst = 1'b0;
        #1;
        chk_all_zero("abort_async");
        @(negedge clk);
        nrst = 1'b1;
        bad_after = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) bad_after = 1'b1;
        end
        chk("abort_no_done_after", 32'(bad_after), 32'd0);
        chk_all_zero("abort_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
